// File: rtl/index_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | index_sequencer                                                        |
// | Emits 3-bit converter table indices 0..LAST_IDX (or reverse), each     |
// | held TICK_DIV cycles. Optional pause input enabled by SEQ_PAUSE_EN.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module index_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int LAST_IDX = 7
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       dir_i,
  input  logic       loop_i,
`ifdef SEQ_PAUSE_EN
  input  logic       pause_i,
`endif
  output logic [2:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
  localparam logic [2:0]         c_last = 3'(LAST_IDX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_presc;
  logic [c_cnt_w-1:0]   w_presc_nxt;
  logic [2:0]           r_data;
  logic [2:0]           w_data_nxt;
  logic                 r_dir;
  logic                 w_dir_nxt;
  logic                 w_pause;
  logic                 w_at_term;
  logic                 w_at_last;
  logic [2:0]           w_first;
  logic [2:0]           w_step;

`ifdef SEQ_PAUSE_EN
  assign w_pause = pause_i;
`else
  assign w_pause = 1'b0;
`endif

  // Direction-dependent pass boundaries use the latched direction.
  assign w_at_term = (r_presc == c_term);
  assign w_at_last = (r_data == (r_dir ? 3'd0 : c_last));
  assign w_first   = r_dir ? c_last : 3'd0;
  assign w_step    = r_dir ? (r_data - 3'd1) : (r_data + 3'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_data  <= 3'd0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_data  <= w_data_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_data_nxt  = r_data;
    w_dir_nxt   = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          w_state_nxt = ST_RUN;
          w_presc_nxt = '0;
          w_dir_nxt   = dir_i;
          w_data_nxt  = dir_i ? c_last : 3'd0;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_pause) begin
          if (w_at_term) begin
            w_presc_nxt = '0;
            if (!w_at_last) begin
              w_data_nxt = w_step;
            end else if (loop_i) begin
              w_data_nxt = w_first;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_presc_nxt = r_presc + c_one;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign data_o  = r_data;
  assign valid_o = (r_state == ST_RUN);
  assign busy_o  = (r_state == ST_RUN);
  assign done_o  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_index_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_index_sequencer                                                     |
// | Random stimulus on three parameter sets against a position-based model.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_index_sequencer;

  localparam int N = 3;
  localparam int TD [N] = '{3, 1, 2};
  localparam int LI [N] = '{5, 0, 7};
`ifdef SEQ_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop, dir, loop, pause;
  logic [2:0] data  [N];
  logic       valid [N];
  logic       busy  [N];
  logic       done  [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      index_sequencer #(.TICK_DIV(TD[g]), .LAST_IDX(LI[g])) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .stop_i  (stop),
        .dir_i   (dir),
        .loop_i  (loop),
`ifdef SEQ_PAUSE_EN
        .pause_i (pause),
`endif
        .data_o  (data[g]),
        .valid_o (valid[g]),
        .busy_o  (busy[g]),
        .done_o  (done[g])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: mode 0=idle 1=run 2=done; pos counts cycles since pass start.
  int m_mode [N];
  int m_pos  [N];
  int m_dir  [N];
  int m_data [N];

  function automatic int idx_at(input int k);
    int p;
    p = m_pos[k] / TD[k];
    return (m_dir[k] != 0) ? (LI[k] - p) : p;
  endfunction

  task automatic model_step(input int k);
    if (!rst_n) begin
      m_mode[k] = 0; m_pos[k] = 0; m_data[k] = 0;
    end else begin
      case (m_mode[k])
        0: if (start && !stop) begin
             m_mode[k] = 1; m_pos[k] = 0; m_dir[k] = int'(dir);
             m_data[k] = idx_at(k);
           end
        1: if (stop) m_mode[k] = 0;
           else if (!(PAUSE_ON && pause)) begin
             if (m_pos[k] == (LI[k] + 1) * TD[k] - 1) begin
               if (loop) begin m_pos[k] = 0; m_data[k] = idx_at(k); end
               else m_mode[k] = 2;
             end else begin
               m_pos[k]++;
               m_data[k] = idx_at(k);
             end
           end
        default: m_mode[k] = 0;
      endcase
    end
  endtask

  int reset_left;

  initial begin
    for (int k = 0; k < N; k++) begin
      m_mode[k] = 0; m_pos[k] = 0; m_dir[k] = 0; m_data[k] = 0;
    end
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; loop = 1'b0; pause = 1'b0;
    reset_left = 1;
    for (int k = 0; k < N; k++) model_step(k);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check($sformatf("data[%0d]", k),  32'(data[k]),  32'(m_data[k]));
        check($sformatf("valid[%0d]", k), 32'(valid[k]), 32'(m_mode[k] == 1));
        check($sformatf("busy[%0d]", k),  32'(busy[k]),  32'(m_mode[k] == 1));
        check($sformatf("done[%0d]", k),  32'(done[k]),  32'(m_mode[k] == 2));
      end
      if (reset_left > 0) begin
        rst_n = 1'b0; reset_left--;
      end else if ($urandom % 400 == 0) begin
        rst_n = 1'b0; reset_left = 1;
      end else begin
        rst_n = 1'b1;
      end
      // Middle phase holds start high to exercise DONE -> IDLE -> restart.
      if (cyc >= 1000 && cyc < 1600) start = 1'b1;
      else start = ($urandom % 4 == 0);
      stop  = ($urandom % 60 == 0);
      if (cyc >= 2200 && cyc < 2400) stop = start;
      dir   = $urandom % 2 == 1;
      if ($urandom % 20 == 0) loop = ~loop;
      pause = ($urandom % 8 == 0);
      for (int k = 0; k < N; k++) model_step(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
